// File: rtl/gray_adjust_pipe.sv
// gray_adjust_pipe: per-channel contrast gain around mid-grey, signed
// brightness offset and saturation. The pipe is three stages deep with a
// single global advance. Configuration is double-buffered and commits only
// on an accepted start-of-frame beat. A per-frame clip count is kept.

// One channel of the datapath. Each beat's config snapshot is supplied by
// the top level, aligned to the stage that uses it.
module gray_adjust_lane #(
  parameter int DATA_W    = 8,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_adv,
  input  logic [DATA_W-1:0] i_x,
  input  logic [GAIN_W-1:0] i_gain,   // gain of the beat entering S1
  input  logic [DATA_W:0]   i_off,    // offset of the beat held in S1
  input  logic              i_enb,    // enable of the beat held in S2
  output logic [DATA_W-1:0] o_y,
  output logic              o_clip
);
  localparam int PW = DATA_W + GAIN_W + 2;  // signed product width
  localparam int TW = PW + 1;               // headroom for +MID +offset
  localparam logic [DATA_W:0] MID = {2'b01, {(DATA_W-1){1'b0}}};
  localparam logic [PW-1:0]   RND = {{(PW-1){1'b0}}, 1'b1} << (GAIN_FRAC-1);

  logic signed [DATA_W:0] w_xc;
  logic signed [PW-1:0]   w_d, w_sum, w_r;
  logic [TW-1:0]          w_t;
  logic                   w_neg, w_ovf;
  logic signed [PW-1:0]   r_d;
  logic [DATA_W-1:0]      r_x1, r_x2;
  logic [TW-1:0]          r_t;

  assign w_xc  = $signed({1'b0, i_x} - MID);
  assign w_d   = $signed({{(GAIN_W+1){w_xc[DATA_W]}}, w_xc})
               * $signed({{(DATA_W+2){1'b0}}, i_gain});
  assign w_sum = r_d + $signed(RND);
  assign w_r   = w_sum >>> GAIN_FRAC;           // floor(x + 0.5): round half up
  assign w_t   = {w_r[PW-1], w_r}
               + {{(GAIN_W+2){1'b0}}, MID}
               + {{(GAIN_W+2){i_off[DATA_W]}}, i_off};
  assign w_neg = r_t[TW-1];
  assign w_ovf = !w_neg && (|r_t[TW-2:DATA_W]);

  // Three datapath stages: multiply, round+offset, clamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d    <= '0;
      r_x1   <= '0;
      r_t    <= '0;
      r_x2   <= '0;
      o_y    <= '0;
      o_clip <= 1'b0;
    end else if (i_adv) begin
      r_d    <= w_d;
      r_x1   <= i_x;
      r_t    <= w_t;
      r_x2   <= r_x1;
      if (!i_enb)     o_y <= r_x2;
      else if (w_neg) o_y <= '0;
      else if (w_ovf) o_y <= '1;
      else            o_y <= r_t[DATA_W-1:0];
      o_clip <= i_enb && (w_neg || w_ovf);
    end
  end
endmodule

module gray_adjust_pipe #(
  parameter int DATA_W    = 8,
  parameter int CH        = 1,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 6,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [CH*DATA_W-1:0] s_data,
  input  logic                 s_sof,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [CH*DATA_W-1:0] m_data,
  output logic                 m_sof,
  input  logic [GAIN_W-1:0]    cfg_gain,
  input  logic [DATA_W:0]      cfg_offset,
  input  logic                 cfg_enable,
  input  logic                 cfg_update,
  output logic                 cfg_pending,
  output logic [CNT_W-1:0]     clip_cnt
);
  localparam logic [GAIN_W-1:0] UNITY = {{(GAIN_W-1){1'b0}}, 1'b1} << GAIN_FRAC;

  logic [3:1]        vld_pipe;
  logic [3:1]        r_sof;
  logic              w_en, w_acc, w_commit, w_xfer;
  logic [GAIN_W-1:0] r_gain, w_gain;
  logic [DATA_W:0]   r_off, w_off, r_s1_off;
  logic              r_enb, w_enb, r_s1_enb, r_s2_enb;
  logic [CH-1:0]     w_clip;
  logic [CNT_W-1:0]  w_pc;
  logic [CNT_W:0]    w_acc_sum;

  assign w_en     = !vld_pipe[3] || m_ready;
  assign s_ready  = w_en;
  assign m_valid  = vld_pipe[3];
  assign m_sof    = r_sof[3];
  assign w_acc    = s_valid && w_en;
  assign w_xfer   = m_valid && m_ready;
  assign w_commit = w_acc && s_sof && (cfg_pending || cfg_update);

  // A committing sof beat already sees the new settings.
  assign w_gain = w_commit ? cfg_gain   : r_gain;
  assign w_off  = w_commit ? cfg_offset : r_off;
  assign w_enb  = w_commit ? cfg_enable : r_enb;

  // Active config and the pending-update flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gain      <= UNITY;
      r_off       <= '0;
      r_enb       <= 1'b0;
      cfg_pending <= 1'b0;
    end else if (w_commit) begin
      r_gain      <= cfg_gain;
      r_off       <= cfg_offset;
      r_enb       <= cfg_enable;
      cfg_pending <= 1'b0;
    end else if (cfg_update) begin
      cfg_pending <= 1'b1;
    end
  end

  // Valid/sof shift registers and per-beat config snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      r_sof    <= '0;
      r_s1_off <= '0;
      r_s1_enb <= 1'b0;
      r_s2_enb <= 1'b0;
    end else if (w_en) begin
      vld_pipe <= {vld_pipe[2:1], s_valid};
      r_sof    <= {r_sof[2:1], s_sof};
      r_s1_off <= w_off;
      r_s1_enb <= w_enb;
      r_s2_enb <= r_s1_enb;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    gray_adjust_lane #(
      .DATA_W(DATA_W), .GAIN_W(GAIN_W), .GAIN_FRAC(GAIN_FRAC)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_adv  (w_en),
      .i_x    (s_data[c*DATA_W +: DATA_W]),
      .i_gain (w_gain),
      .i_off  (r_s1_off),
      .i_enb  (r_s2_enb),
      .o_y    (m_data[c*DATA_W +: DATA_W]),
      .o_clip (w_clip[c])
    );
  end

  // Number of clamped channels in the output beat.
  always_comb begin
    w_pc = '0;
    for (int c = 0; c < CH; c++) w_pc = w_pc + CNT_W'(w_clip[c]);
  end

  assign w_acc_sum = {1'b0, clip_cnt} + {1'b0, w_pc};

  // Per-frame clip counter: restarts on output sof, saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          clip_cnt <= '0;
    else if (w_xfer) begin
      if (m_sof)                clip_cnt <= w_pc;
      else if (w_acc_sum[CNT_W]) clip_cnt <= '1;
      else                      clip_cnt <= w_acc_sum[CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_gray_adjust_pipe.sv
// Bench for gray_adjust_pipe (CH=3): directed frames with literal
// expectations, randomized backpressure against a behavioural model, and
// reset with beats in flight.
module tb_gray_adjust_pipe;
  localparam int DW = 8, CH = 3, GW = 8, GF = 6, CW = 16;

  logic              clk = 0, rst_n = 0;
  logic              s_valid = 0, s_sof = 0, m_ready = 1;
  logic              s_ready, m_valid, m_sof, cfg_pending;
  logic [CH*DW-1:0]  s_data = '0, m_data;
  logic [GW-1:0]     cfg_gain = 8'd64;
  logic [DW:0]       cfg_offset = '0;
  logic              cfg_enable = 0, cfg_update = 0;
  logic [CW-1:0]     clip_cnt;

  always #5 clk = ~clk;

  gray_adjust_pipe #(.DATA_W(DW), .CH(CH), .GAIN_W(GW), .GAIN_FRAC(GF), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof),
    .cfg_gain(cfg_gain), .cfg_offset(cfg_offset), .cfg_enable(cfg_enable),
    .cfg_update(cfg_update), .cfg_pending(cfg_pending), .clip_cnt(clip_cnt)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", nm, act, req);
    end
  endtask

  // Reference arithmetic straight from the definition, in reals/ints.
  function automatic int adj(input int x, input int g, input int off, input bit en, output bit clip);
    real r;
    int  t;
    clip = 0;
    if (!en) return x;
    r = $floor((real'((x - 128) * g) + 32.0) / 64.0);
    t = int'(r) + 128 + off;
    if (t < 0)   begin clip = 1; return 0;   end
    if (t > 255) begin clip = 1; return 255; end
    return t;
  endfunction

  function automatic logic [CH*DW-1:0] pk(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return {c, b, a};
  endfunction

  // Model state
  int               a_gain = 64, a_off = 0;
  bit               a_en = 0, pend = 0;
  int               exp_clip = 0;
  logic [CH*DW:0]   exp_q[$];
  int               expc_q[$];
  logic [CH*DW-1:0] out_log[$];
  int               cyc = 0, first_acc = -1, first_out = -1;
  bit               stall = 0;
  logic [CH*DW-1:0] st_data;
  logic             st_sof;
  logic [CH*DW:0]   e;
  int               pc, y;
  bit               cl;

  // Single compare process: model update and DUT check each cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_sof", m_sof, 0);
      chk("rst_pending", cfg_pending, 0);
      chk("rst_clip_cnt", clip_cnt, 0);
      exp_q.delete(); expc_q.delete();
      a_gain = 64; a_off = 0; a_en = 0; pend = 0; exp_clip = 0; stall = 0;
    end else begin
      chk("s_ready", s_ready, !m_valid || m_ready);
      chk("cfg_pending", cfg_pending, pend);
      chk("clip_cnt", clip_cnt, exp_clip);
      if (stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, st_data);
        chk("stall_sof", m_sof, st_sof);
      end
      stall = m_valid && !m_ready; st_data = m_data; st_sof = m_sof;
      if (m_valid && m_ready) begin
        if (first_out < 0) first_out = cyc;
        out_log.push_back(m_data);
        if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          e = exp_q.pop_front(); pc = expc_q.pop_front();
          chk("m_data", m_data, e[CH*DW-1:0]);
          chk("m_sof", m_sof, e[CH*DW]);
          if (m_sof) exp_clip = pc;
          else       exp_clip = (exp_clip + pc > 65535) ? 65535 : exp_clip + pc;
        end
      end
      if (s_valid && s_ready) begin
        if (first_acc < 0) first_acc = cyc;
        if (s_sof && (pend || cfg_update)) begin
          a_gain = cfg_gain; a_off = $signed(cfg_offset); a_en = cfg_enable; pend = 0;
        end else if (cfg_update) pend = 1;
        e = '0; pc = 0;
        for (int c = 0; c < CH; c++) begin
          y = adj(int'(s_data[c*DW +: DW]), a_gain, a_off, a_en, cl);
          e[c*DW +: DW] = y[DW-1:0];
          pc += int'(cl);
        end
        e[CH*DW] = s_sof;
        exp_q.push_back(e); expc_q.push_back(pc);
      end else if (cfg_update) pend = 1;
    end
  end

  task automatic tick; @(posedge clk); #1; endtask

  task automatic beat(input logic [CH*DW-1:0] d, input bit sof, input bit upd);
    bit acc;
    int n = 0;
    s_valid = 1; s_data = d; s_sof = sof; cfg_update = upd;
    do begin acc = s_ready; tick; cfg_update = 0; n++; end while (!acc && n < 200);
    if (!acc) chk("accept_timeout", 0, 1);
    s_valid = 0; s_sof = 0;
  endtask

  task automatic drain;
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 1000) begin tick; n++; end
    if (n >= 1000) chk("drain_timeout", 0, 1);
    tick; tick;
  endtask

  int n0, sent;
  bit holding, acc;

  initial begin
    // Model pins
    y = adj(101, 32, 0, 1, cl);   chk("pin_round", y, 115);
    y = adj(230, 64, 40, 1, cl);  chk("pin_sat_hi", y, 255); chk("pin_sat_flag", cl, 1);
    y = adj(100, 128, 0, 1, cl);  chk("pin_gain2", y, 72);
    y = adj(10, 64, -200, 1, cl); chk("pin_sat_lo", y, 0);

    repeat (3) tick;
    rst_n = 1; tick;

    // Default config is passthrough
    for (int i = 0; i < 10; i++) beat(pk(200, 128, 0), i == 0, 0);
    drain;
    chk("latency", first_out - first_acc, 3);
    chk("t1_data", out_log[0], pk(200, 128, 0));
    chk("t1_data_last", out_log[9], pk(200, 128, 0));
    chk("t1_clip", clip_cnt, 0);

    // Gain 1.0, offset +40
    cfg_gain = 8'd64; cfg_offset = 9'd40; cfg_enable = 1; cfg_update = 1; tick; cfg_update = 0;
    chk("t2_pend_set", cfg_pending, 1);
    n0 = out_log.size();
    beat(pk(200, 230, 10), 1, 0);
    chk("t2_pend_clr", cfg_pending, 0);
    drain;
    chk("t2_data", out_log[n0], pk(240, 255, 50));
    chk("t2_clip", clip_cnt, 1);

    // Gain 2.0, then 0.5 with rounding; update in the same cycle as sof
    cfg_gain = 8'd128; cfg_offset = 9'd0;
    n0 = out_log.size();
    beat(pk(100, 200, 128), 1, 1);
    cfg_gain = 8'd32;
    beat(pk(101, 101, 101), 1, 1);
    drain;
    chk("t3_gain2", out_log[n0], pk(72, 255, 128));
    chk("t3_round", out_log[n0+1], pk(115, 115, 115));
    chk("t3_clip", clip_cnt, 0);

    // Mid-frame update waits for next sof
    n0 = out_log.size();
    beat(pk(50, 50, 50), 0, 0);
    cfg_gain = 8'd64; cfg_offset = 9'(-20);
    beat(pk(50, 50, 50), 0, 1);
    chk("t4_pend_mid", cfg_pending, 1);
    beat(pk(50, 50, 50), 0, 0);
    chk("t4_pend_hold", cfg_pending, 1);
    beat(pk(50, 50, 50), 1, 0);
    chk("t4_pend_clr", cfg_pending, 0);
    drain;
    chk("t4_old_cfg", out_log[n0+2], pk(89, 89, 89));
    chk("t4_new_cfg", out_log[n0+3], pk(30, 30, 30));

    // Random traffic with 50% backpressure
    n0 = out_log.size();
    sent = 0; holding = 0;
    while (sent < 1000) begin
      m_ready = 1'($urandom_range(0, 1));
      if (!holding) begin
        if ($urandom_range(0, 3) != 0) begin
          s_valid = 1; s_data = 24'($urandom); s_sof = (sent % 50 == 0); holding = 1;
          if (!cfg_pending && $urandom_range(0, 9) == 0) begin
            cfg_gain = 8'($urandom); cfg_offset = 9'($urandom);
            cfg_enable = ($urandom_range(0, 3) != 0); cfg_update = 1;
          end
        end else s_valid = 0;
      end
      #1;
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      cfg_update = 0;
      if (acc) begin holding = 0; sent++; s_valid = 0; s_sof = 0; end
    end
    s_valid = 0; m_ready = 1;
    drain;
    chk("rand_count", out_log.size() - n0, 1000);

    // Reset with beats in flight
    cfg_gain = 8'd128; cfg_offset = 9'd10; cfg_enable = 1;
    beat(pk(1, 2, 3), 1, 1);
    beat(pk(4, 5, 6), 0, 0);
    cfg_update = 1;
    beat(pk(7, 8, 9), 0, 0);
    chk("pre_rst_valid", m_valid, 1);
    rst_n = 0; #1;
    chk("rst_now_valid", m_valid, 0);
    chk("rst_now_data", m_data, 0);
    chk("rst_now_pend", cfg_pending, 0);
    tick; tick;
    rst_n = 1; tick;
    n0 = out_log.size();
    beat(pk(200, 230, 10), 0, 0);
    drain;
    chk("post_rst_count", out_log.size() - n0, 1);
    chk("post_rst_passthru", out_log[n0], pk(200, 230, 10));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
